// File: rtl/riscv_bpred.sv
// riscv_bpred: direct-mapped BTB with per-entry saturating counters.
// Fetch-side lookup and Execute-side resolution are both combinational;
// training happens on the rising edge of clk while e_valid is high.
// Optional statistics counters are built when RISCV_BPRED_STATS_EN is defined;
// otherwise stat_branches/stat_mispred are tied to zero.
module riscv_bpred #(
  parameter int ENTRIES = 16,
  parameter int CNT_W   = 2,
  parameter int XLEN    = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] f_pc,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target,
  input  logic            e_valid,
  input  logic            e_is_jump,
  input  logic [XLEN-1:0] e_pc,
  input  logic            e_taken,
  input  logic [XLEN-1:0] e_target,
  input  logic            e_pred_taken,
  input  logic [XLEN-1:0] e_pred_target,
  output logic            mispredict,
  output logic [XLEN-1:0] redirect_pc,
  output logic [31:0]     stat_branches,
  output logic [31:0]     stat_mispred
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = XLEN - IDX_W - 2;

  // Counter landmarks: saturation limit, weakly-taken (allocate), weakly-not-taken (reset)
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_WT  = CNT_W'(1) << (CNT_W - 1);
  localparam logic [CNT_W-1:0] CNT_WNT = CNT_WT - CNT_W'(1);

  logic             r_valid  [ENTRIES];
  logic [TAG_W-1:0] r_tag    [ENTRIES];
  logic [XLEN-1:0]  r_target [ENTRIES];
  logic             r_jump   [ENTRIES];
  logic [CNT_W-1:0] r_cnt    [ENTRIES];

  logic [IDX_W-1:0] w_f_idx;
  logic [TAG_W-1:0] w_f_tag;
  logic             w_f_hit;
  logic [IDX_W-1:0] w_e_idx;
  logic [TAG_W-1:0] w_e_tag;
  logic             w_e_hit;
  logic             w_unused;

  // PCs are word aligned, so the byte-offset bits of the fetch PC carry no information
  assign w_unused = ^f_pc[1:0];

  assign w_f_idx = f_pc[IDX_W+1:2];
  assign w_f_tag = f_pc[XLEN-1:IDX_W+2];
  assign w_e_idx = e_pc[IDX_W+1:2];
  assign w_e_tag = e_pc[XLEN-1:IDX_W+2];

  // Fetch lookup: predict taken on a tag hit whose entry is a jump or leans taken
  always_comb begin
    w_f_hit     = r_valid[w_f_idx] && (r_tag[w_f_idx] == w_f_tag);
    pred_taken  = 1'b0;
    pred_target = {XLEN{1'b0}};
    if (w_f_hit && (r_jump[w_f_idx] || r_cnt[w_f_idx][CNT_W-1])) begin
      pred_taken  = 1'b1;
      pred_target = r_target[w_f_idx];
    end else begin
      pred_taken  = 1'b0;
      pred_target = {XLEN{1'b0}};
    end
  end

  // Execute resolution: compare actual outcome with the carried prediction
  always_comb begin
    mispredict  = 1'b0;
    redirect_pc = {XLEN{1'b0}};
    if (e_valid) begin
      mispredict  = (e_pred_taken != e_taken) || (e_taken && (e_pred_target != e_target));
      redirect_pc = e_taken ? e_target : (e_pc + XLEN'(4));
    end else begin
      mispredict  = 1'b0;
      redirect_pc = {XLEN{1'b0}};
    end
  end

  assign w_e_hit = r_valid[w_e_idx] && (r_tag[w_e_idx] == w_e_tag);

  // BTB training: saturate counters on hits, allocate on taken misses
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_valid[i]  <= 1'b0;
        r_tag[i]    <= {TAG_W{1'b0}};
        r_target[i] <= {XLEN{1'b0}};
        r_jump[i]   <= 1'b0;
        r_cnt[i]    <= CNT_WNT;
      end
    end else if (e_valid) begin
      if (w_e_hit) begin
        if (e_taken) begin
          if (r_cnt[w_e_idx] != CNT_MAX) begin
            r_cnt[w_e_idx] <= r_cnt[w_e_idx] + CNT_W'(1);
          end
          r_target[w_e_idx] <= e_target;
          r_jump[w_e_idx]   <= e_is_jump;
        end else if (r_cnt[w_e_idx] != {CNT_W{1'b0}}) begin
          r_cnt[w_e_idx] <= r_cnt[w_e_idx] - CNT_W'(1);
        end
      end else if (e_taken) begin
        r_valid[w_e_idx]  <= 1'b1;
        r_tag[w_e_idx]    <= w_e_tag;
        r_target[w_e_idx] <= e_target;
        r_jump[w_e_idx]   <= e_is_jump;
        r_cnt[w_e_idx]    <= CNT_WT;
      end
    end
  end

`ifdef RISCV_BPRED_STATS_EN
  logic [31:0] r_stat_br;
  logic [31:0] r_stat_mp;

  // Saturating event counters for resolved branches and mispredictions
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stat_br <= 32'h0000_0000;
      r_stat_mp <= 32'h0000_0000;
    end else begin
      if (e_valid && (r_stat_br != 32'hFFFF_FFFF)) begin
        r_stat_br <= r_stat_br + 32'h0000_0001;
      end
      if (mispredict && (r_stat_mp != 32'hFFFF_FFFF)) begin
        r_stat_mp <= r_stat_mp + 32'h0000_0001;
      end
    end
  end

  assign stat_branches = r_stat_br;
  assign stat_mispred  = r_stat_mp;
`else
  assign stat_branches = 32'h0000_0000;
  assign stat_mispred  = 32'h0000_0000;
`endif

endmodule

// File: tb/tb_riscv_bpred.sv
// Testbench for riscv_bpred: directed vector table, mid-run reset sequence,
// and randomized traffic checked against an array-based behavioural model.
module tb_riscv_bpred;

  localparam int ENTRIES = 16;
  localparam int CNT_W   = 2;
  localparam int XLEN    = 32;
  localparam int IDX_W   = $clog2(ENTRIES);

  logic        clk;
  logic        rst;
  logic [31:0] f_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        e_valid;
  logic        e_is_jump;
  logic [31:0] e_pc;
  logic        e_taken;
  logic [31:0] e_target;
  logic        e_pred_taken;
  logic [31:0] e_pred_target;
  logic        mispredict;
  logic [31:0] redirect_pc;
  logic [31:0] stat_branches;
  logic [31:0] stat_mispred;

  riscv_bpred #(.ENTRIES(ENTRIES), .CNT_W(CNT_W), .XLEN(XLEN)) dut (
    .clk(clk), .rst(rst), .f_pc(f_pc),
    .pred_taken(pred_taken), .pred_target(pred_target),
    .e_valid(e_valid), .e_is_jump(e_is_jump), .e_pc(e_pc),
    .e_taken(e_taken), .e_target(e_target),
    .e_pred_taken(e_pred_taken), .e_pred_target(e_pred_target),
    .mispredict(mispredict), .redirect_pc(redirect_pc),
    .stat_branches(stat_branches), .stat_mispred(stat_mispred)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] f_pc;
    logic        ev;
    logic        ej;
    logic [31:0] epc;
    logic        et;
    logic [31:0] etg;
    logic        ept;
    logic [31:0] eptg;
    logic        x_pt;
    logic [31:0] x_ptg;
    logic        x_mp;
    logic [31:0] x_rd;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;

  // Behavioural model: plain arrays indexed by word address modulo table size
  bit          m_valid [ENTRIES];
  logic [31:0] m_tag   [ENTRIES];
  logic [31:0] m_tgt   [ENTRIES];
  bit          m_jump  [ENTRIES];
  int          m_cnt   [ENTRIES];
  longint      m_br;
  longint      m_mp;

  function automatic vec_t mk(logic [31:0] fp, logic ev, logic ej, logic [31:0] epc, logic et,
                              logic [31:0] etg, logic ept, logic [31:0] eptg, logic xpt,
                              logic [31:0] xptg, logic xmp, logic [31:0] xrd);
    vec_t v;
    v.f_pc = fp; v.ev = ev; v.ej = ej; v.epc = epc; v.et = et; v.etg = etg;
    v.ept = ept; v.eptg = eptg; v.x_pt = xpt; v.x_ptg = xptg; v.x_mp = xmp; v.x_rd = xrd;
    return v;
  endfunction

  function automatic int idx_of(logic [31:0] pc);
    return int'((pc / 4) % ENTRIES);
  endfunction

  function automatic logic [31:0] tag_of(logic [31:0] pc);
    return pc / (4 * ENTRIES);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < ENTRIES; i++) begin
      m_valid[i] = 1'b0;
      m_tag[i]   = 32'h0;
      m_tgt[i]   = 32'h0;
      m_jump[i]  = 1'b0;
      m_cnt[i]   = (1 << (CNT_W - 1)) - 1;
    end
    m_br = 0;
    m_mp = 0;
  endtask

  task automatic model_pred(input logic [31:0] pc, output logic pt, output logic [31:0] tg);
    int k;
    k  = idx_of(pc);
    pt = m_valid[k] && (m_tag[k] == tag_of(pc)) && (m_jump[k] || (m_cnt[k] >= (1 << (CNT_W - 1))));
    tg = pt ? m_tgt[k] : 32'h0;
  endtask

  function automatic logic model_mp(vec_t v);
    return v.ev && ((v.ept != v.et) || (v.et && (v.eptg != v.etg)));
  endfunction

  function automatic logic [31:0] model_rd(vec_t v);
    if (!v.ev) return 32'h0;
    return v.et ? v.etg : v.epc + 32'd4;
  endfunction

  task automatic model_update(vec_t v);
    int k;
    if (!v.ev) return;
    k = idx_of(v.epc);
    if (model_mp(v) && m_mp < 64'hFFFF_FFFF) m_mp++;
    if (m_br < 64'hFFFF_FFFF) m_br++;
    if (m_valid[k] && m_tag[k] == tag_of(v.epc)) begin
      if (v.et) begin
        if (m_cnt[k] < (1 << CNT_W) - 1) m_cnt[k]++;
        m_tgt[k]  = v.etg;
        m_jump[k] = v.ej;
      end else if (m_cnt[k] > 0) begin
        m_cnt[k]--;
      end
    end else if (v.et) begin
      m_valid[k] = 1'b1;
      m_tag[k]   = tag_of(v.epc);
      m_tgt[k]   = v.etg;
      m_jump[k]  = v.ej;
      m_cnt[k]   = 1 << (CNT_W - 1);
    end
  endtask

  function automatic logic [31:0] exp_stat(longint c);
`ifdef RISCV_BPRED_STATS_EN
    return c[31:0];
`else
    return 32'h0 & c[31:0];
`endif
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(vec_t v);
    f_pc = v.f_pc; e_valid = v.ev; e_is_jump = v.ej; e_pc = v.epc; e_taken = v.et;
    e_target = v.etg; e_pred_taken = v.ept; e_pred_target = v.eptg;
  endtask

  // One clock cycle: drive, check combinational outputs, then let the edge train
  task automatic run_cycle(vec_t v, bit use_tbl, string tag);
    logic        mpt;
    logic [31:0] mptg;
    @(negedge clk);
    drive(v);
    #2;
    model_pred(v.f_pc, mpt, mptg);
    if (use_tbl) begin
      chk({tag, ".pred_taken"}, pred_taken, v.x_pt);
      chk({tag, ".pred_target"}, pred_target, v.x_ptg);
      chk({tag, ".mispredict"}, mispredict, v.x_mp);
      chk({tag, ".redirect_pc"}, redirect_pc, v.x_rd);
    end else begin
      chk({tag, ".pred_taken"}, pred_taken, mpt);
      chk({tag, ".pred_target"}, pred_target, mptg);
      chk({tag, ".mispredict"}, mispredict, model_mp(v));
      chk({tag, ".redirect_pc"}, redirect_pc, model_rd(v));
    end
    chk({tag, ".stat_branches"}, stat_branches, exp_stat(m_br));
    chk({tag, ".stat_mispred"}, stat_mispred, exp_stat(m_mp));
    @(posedge clk);
    #1;
    model_update(v);
  endtask

  vec_t tbl [21];
  vec_t idle;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle = mk(32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    //          f_pc   ev ej  e_pc   et  e_tgt  ept  ept_tg   xpt  xptg   xmp  xrd
    tbl[0]  = mk(32'h00, 0, 0, 32'h00, 0, 32'h00,  0, 32'h00,  0, 32'h00,  0, 32'h00);
    tbl[1]  = mk(32'h00, 1, 0, 32'h00, 1, 32'h14,  0, 32'h00,  0, 32'h00,  1, 32'h14);
    tbl[2]  = mk(32'h00, 1, 0, 32'h00, 0, 32'h00,  1, 32'h14,  1, 32'h14,  1, 32'h04);
    tbl[3]  = mk(32'h00, 0, 0, 32'h00, 0, 32'h00,  0, 32'h00,  0, 32'h00,  0, 32'h00);
    tbl[4]  = mk(32'h08, 1, 0, 32'h08, 1, 32'h20,  0, 32'h00,  0, 32'h00,  1, 32'h20);
    tbl[5]  = mk(32'h08, 1, 0, 32'h08, 1, 32'h20,  1, 32'h20,  1, 32'h20,  0, 32'h20);
    tbl[6]  = mk(32'h08, 1, 0, 32'h08, 1, 32'h20,  1, 32'h20,  1, 32'h20,  0, 32'h20);
    tbl[7]  = mk(32'h08, 1, 0, 32'h08, 1, 32'h20,  1, 32'h20,  1, 32'h20,  0, 32'h20);
    tbl[8]  = mk(32'h08, 1, 0, 32'h08, 0, 32'h00,  1, 32'h20,  1, 32'h20,  1, 32'h0C);
    tbl[9]  = mk(32'h08, 0, 0, 32'h00, 0, 32'h00,  0, 32'h00,  1, 32'h20,  0, 32'h00);
    tbl[10] = mk(32'h40, 1, 0, 32'h00, 1, 32'h14,  0, 32'h00,  0, 32'h00,  1, 32'h14);
    tbl[11] = mk(32'h00, 0, 0, 32'h00, 0, 32'h00,  0, 32'h00,  1, 32'h14,  0, 32'h00);
    tbl[12] = mk(32'h40, 0, 0, 32'h00, 0, 32'h00,  0, 32'h00,  0, 32'h00,  0, 32'h00);
    tbl[13] = mk(32'h00, 1, 0, 32'h40, 1, 32'h80,  0, 32'h00,  1, 32'h14,  1, 32'h80);
    tbl[14] = mk(32'h00, 0, 0, 32'h00, 0, 32'h00,  0, 32'h00,  0, 32'h00,  0, 32'h00);
    tbl[15] = mk(32'h40, 0, 0, 32'h00, 0, 32'h00,  0, 32'h00,  1, 32'h80,  0, 32'h00);
    tbl[16] = mk(32'h10, 1, 1, 32'h10, 1, 32'h100, 0, 32'h00,  0, 32'h00,  1, 32'h100);
    tbl[17] = mk(32'h10, 1, 1, 32'h10, 1, 32'h200, 1, 32'h100, 1, 32'h100, 1, 32'h200);
    tbl[18] = mk(32'h10, 0, 0, 32'h00, 0, 32'h00,  0, 32'h00,  1, 32'h200, 0, 32'h00);
    tbl[19] = mk(32'h00, 0, 0, 32'h24, 1, 32'h300, 0, 32'h00,  0, 32'h00,  0, 32'h00);
    tbl[20] = mk(32'h24, 0, 0, 32'h00, 0, 32'h00,  0, 32'h00,  0, 32'h00,  0, 32'h00);

    // Power-on reset state
    rst = 1'b0;
    drive(idle);
    model_reset();
    #2;
    chk("reset.pred_taken", pred_taken, 1'b0);
    chk("reset.pred_target", pred_target, 32'h0);
    chk("reset.stat_branches", stat_branches, 32'h0);
    chk("reset.stat_mispred", stat_mispred, 32'h0);
    @(negedge clk);
    rst = 1'b1;

    // Directed vectors: training, hysteresis, aliasing, target change, idle Execute
    for (int i = 0; i < 4; i++) run_cycle(tbl[i], 1'b1, $sformatf("vec%0d", i));
`ifdef RISCV_BPRED_STATS_EN
    chk("stats2.branches", stat_branches, 32'd2);
    chk("stats2.mispred", stat_mispred, 32'd2);
`else
    chk("stats2.branches", stat_branches, 32'd0);
    chk("stats2.mispred", stat_mispred, 32'd0);
`endif
    for (int i = 4; i < 21; i++) run_cycle(tbl[i], 1'b1, $sformatf("vec%0d", i));

    // Asynchronous reset mid-cycle, after 0x08 has been trained to predict taken
    @(negedge clk);
    drive(mk(32'h08, 1, 0, 32'h30, 1, 32'h44, 0, 32'h00, 0, 32'h0, 0, 32'h0));
    #2;
    chk("prereset.pred_taken", pred_taken, 1'b1);
    #1 rst = 1'b0;
    #1;
    chk("midreset.pred_taken", pred_taken, 1'b0);
    chk("midreset.pred_target", pred_target, 32'h0);
    chk("midreset.stat_branches", stat_branches, 32'h0);
    chk("midreset.stat_mispred", stat_mispred, 32'h0);
    chk("midreset.mispredict", mispredict, 1'b1);
    chk("midreset.redirect_pc", redirect_pc, 32'h44);
    @(negedge clk);
    drive(idle);
    rst = 1'b1;
    model_reset();
    run_cycle(mk(32'h00, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0, 32'h0), 1'b1, "post0");
    run_cycle(mk(32'h30, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0, 32'h0), 1'b1, "post30");

    // Randomized traffic against the behavioural model
    for (int n = 0; n < 3000; n++) begin
      vec_t v;
      logic        pt;
      logic [31:0] ptg;
      v = idle;
      v.f_pc = 32'($urandom_range(0, 31)) << 2;
      if ($urandom_range(0, 7) == 0) v.f_pc = v.f_pc | 32'h1000_0000;
      v.ev  = ($urandom_range(0, 3) != 0);
      v.ej  = ($urandom_range(0, 3) == 0);
      v.epc = 32'($urandom_range(0, 31)) << 2;
      if ($urandom_range(0, 7) == 0) v.epc = v.epc | 32'h1000_0000;
      v.et  = v.ej ? 1'b1 : 1'($urandom_range(0, 1));
      v.etg = 32'($urandom_range(0, 255)) << 2;
      if ($urandom_range(0, 1) == 1) begin
        model_pred(v.epc, pt, ptg);
        v.ept  = pt;
        v.eptg = ptg;
      end else begin
        v.ept  = 1'($urandom_range(0, 1));
        v.eptg = ($urandom_range(0, 1) == 1) ? v.etg : (32'($urandom_range(0, 255)) << 2);
      end
      run_cycle(v, 1'b0, "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/riscv_bpred.md
# riscv_bpred

Parametrised branch predictor for the pipelined RISC-V core. It holds a direct-mapped branch target buffer (BTB) with per-entry saturating counters. In Fetch it predicts the next PC, so taken branches and jumps no longer always cost a two-instruction flush. In Execute it checks the resolved outcome against the prediction and raises `mispredict` plus `redirect_pc`; the hazard unit uses these to flush Decode/Execute and steer the PC.

## Interface
Parameters:
- `ENTRIES`, 16: number of BTB entries; power of two, ≥2. `IDX_W = $clog2(ENTRIES)`.
- `CNT_W`, 2: saturating-counter width, ≥1.
- `XLEN`, 32: PC width.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `f_pc`  in  XLEN  Fetch-stage PC.
- `pred_taken`  out  1  prediction for `f_pc`: redirect fetch.
- `pred_target`  out  XLEN  predicted target; 0 when `pred_taken`=0.
- `e_valid`  in  1  an un-flushed branch or jump is in Execute this cycle.
- `e_is_jump`  in  1  unconditional (jal/jalr) when 1; conditional branch when 0.
- `e_pc`  in  XLEN  PC of the resolving instruction.
- `e_taken`  in  1  actual outcome (1 for jumps).
- `e_target`  in  XLEN  actual target address.
- `e_pred_taken`  in  1  prediction carried down the pipeline with the instruction.
- `e_pred_target`  in  XLEN  predicted target carried down the pipeline.
- `mispredict`  out  1  Decode and Execute must be flushed; PC must load `redirect_pc`.
- `redirect_pc`  out  XLEN  correct next PC.
- `stat_branches`  out  32  count of resolved branches and jumps.
- `stat_mispred`  out  32  count of mispredictions.

## Operation
- Index = `pc[IDX_W+1:2]`; tag = `pc[XLEN-1:IDX_W+2]`. Each entry holds valid, tag, target, jump flag and a `CNT_W`-bit counter.
- Lookup is a hit when the indexed entry is valid and its tag equals the tag of `f_pc`.
  - `pred_taken` = hit && (jump flag || counter MSB).
  - `pred_target` = entry target when `pred_taken`, else 0.
- Resolution:
  - `mispredict` = `e_valid` && ((`e_pred_taken` != `e_taken`) || (`e_taken` && `e_pred_target` != `e_target`)).
  - `redirect_pc` = `e_taken` ? `e_target` : `e_pc`+4.
  - Both outputs are 0 when `e_valid`=0.
- Update, on the rising edge when `e_valid`=1:
  - On a hit for `e_pc`: the counter saturates up on taken and down on not-taken. It never wraps; the limits are 0 and 2^CNT_W−1. When taken, target and jump flag are rewritten.
  - On a miss with `e_taken`=1: the entry is allocated, overwriting any alias. Valid is set, tag and target are written, jump flag = `e_is_jump`, counter = 2^(CNT_W−1) (weakly taken).
  - On a miss with `e_taken`=0: no change.
- Reset, asynchronous, including mid-operation:
  - All valid bits clear and counters return to 2^(CNT_W−1)−1 (weakly not-taken).
  - `pred_taken`=0, `pred_target`=0, and stats return to 0 immediately.
  - `mispredict` and `redirect_pc` follow their inputs combinationally.

## Timing
- Prediction is combinational from `f_pc`, with a zero-cycle latency, for use in the same Fetch cycle.
- `mispredict`/`redirect_pc` are combinational in the Execute cycle. The hazard unit flushes on the same clock edge.
- An update becomes visible to lookups on the cycle after the resolving edge.
- If Fetch and Execute hit the same index in the same cycle, Fetch sees the pre-update contents.
- A wrong-path instruction flushed before Execute never has `e_valid`=1 and therefore never trains the BTB.

## Configuration
- `RISCV_BPRED_STATS_EN` defined:
  - `stat_branches` increments on every `e_valid`.
  - `stat_mispred` increments on every `mispredict`.
  - Both are 32-bit and saturate at 0xFFFFFFFF.
- Not defined: no counter logic is built, and both stat outputs are tied to 0. Ports remain for interface stability.

## Test plan
- Reset, then `f_pc`=0x00 → `pred_taken`=0, `pred_target`=0, stats 0; assert reset mid-run after training → the next lookup of 0x00 gives `pred_taken`=0.
- Resolve a branch `e_pc`=0x00, `e_taken`=1, `e_target`=0x14, `e_pred_taken`=0 → `mispredict`=1, `redirect_pc`=0x14. Next cycle, `f_pc`=0x00 → `pred_taken`=1, `pred_target`=0x14.
- Same entry resolved not-taken with `e_pred_taken`=1 → `mispredict`=1, `redirect_pc`=0x04. Next cycle, `f_pc`=0x00 → `pred_taken`=0 (counter 01).
- Four taken resolutions of 0x08→0x20, then one not-taken → still `pred_taken`=1 (counter 11→10). Correctly predicted resolutions give `mispredict`=0.
- Aliasing with `ENTRIES`=16: train 0x00→0x14, then `f_pc`=0x40 → `pred_taken`=0. Resolve 0x40 taken to 0x80 → 0x00 no longer predicts.
- Stats, with the macro: after scenarios 2–3 → `stat_branches`=2, `stat_mispred`=2. Without the macro → both 0.
